regfile_writer: RTL and testbench
=================================

REGFILE_WRITER -- requirements
Module: regfile_writer

Interface
REQ-001 Parameter: XLEN, 32, data width of write values.
REQ-002 Parameter: STARVE_LIMIT, 4, consecutive lost arbitration cycles after which the ALU source wins.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 alu_valid  input  1  ALU result offered.
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_val  input  XLEN  ALU result value.
REQ-008 alu_ready  output  1  ALU result accepted this cycle.
REQ-009 mem_valid  input  1  load result offered.
REQ-010 mem_rd  input  5  load destination register.
REQ-011 mem_val  input  XLEN  load result value.
REQ-012 mem_ready  output  1  load result accepted this cycle.
REQ-013 iss_valid  input  1  instruction issued that will later write iss_rd.
REQ-014 iss_rd  input  5  destination of issued instruction.
REQ-015 q_rs1, q_rs2  input  5 each  scoreboard query addresses.
REQ-016 q_rs1_busy, q_rs2_busy  output  1 each  queried register has a pending write.
REQ-017 rd  output  5  regfile write address.
REQ-018 val_w  output  XLEN  regfile write data.
REQ-019 en_w  output  1  regfile write enable.

Function
REQ-020 Handshake: transfer occurs when valid and ready are both high at a rising edge; source SHALL hold rd/val stable while valid is high and ready is low.
REQ-021 ready outputs SHALL be combinational from valid and arbitration state; at most one of alu_ready, mem_ready SHALL be high per cycle.
REQ-022 Arbitration: mem wins when both valid, unless starve counter equals STARVE_LIMIT, in which case alu wins.
REQ-023 Starve counter SHALL increment (saturating at STARVE_LIMIT) each cycle alu_valid is high and alu_ready is low, and clear to 0 whenever alu transfers or alu_valid is low.
REQ-024 A source with valid high and no competitor SHALL be granted the same cycle.
REQ-025 rd, val_w, en_w SHALL be registered: a transfer at edge N drives rd/val_w with en_w=1 during the cycle after edge N (write lands in regfile at edge N+1); latency exactly 1 cycle.
REQ-026 en_w SHALL be 0 in any cycle following an edge with no transfer; rd/val_w hold previous values.
REQ-027 A transfer with rd=0 SHALL be accepted but SHALL produce en_w=0.
REQ-028 Scoreboard: 32-bit busy vector; iss_valid with iss_rd!=0 sets busy[iss_rd] at the edge.
REQ-029 busy[r] SHALL clear at the edge where a transfer to r occurs.
REQ-030 Simultaneous issue and transfer to the same r: set wins, busy[r] stays 1.
REQ-031 busy[0] SHALL always read 0; q_rs*_busy SHALL be combinational reads of busy.

Reset
REQ-032 While rst is high: en_w=0, rd=0, val_w=0, busy vector=0, starve counter=0; alu_ready and mem_ready SHALL be 0.
REQ-033 Reset mid-transfer SHALL discard the pending write; en_w SHALL be 0 in the first cycle after rst deasserts.

Structure
REQ-034 XLEN, REG_ADDR_W=5, NUM_REGS=32, STARVE_LIMIT SHALL live in shared package riscv_pkg.
REQ-035 Scoreboard SHALL be a sub-module wb_scoreboard (set, clear, two query ports).

Verification
REQ-036 alu_valid, alu_rd=5, alu_val=24, mem idle -> alu_ready=1 same cycle; next cycle rd=5, val_w=24, en_w=1.
REQ-037 Both valid (alu rd=3 val=7, mem rd=4 val=9) -> mem first (rd=4, val_w=9), alu next cycle (rd=3, val_w=7).
REQ-038 mem_valid held high for 6 cycles, alu_valid high throughout -> alu_ready=1 on 5th cycle (after 4 losses), otherwise mem.
REQ-039 iss_rd=7 issued, q_rs1=7 -> q_rs1_busy=1; alu write rd=7 -> busy clears after transfer edge; issue rd=7 on same edge as transfer -> busy stays 1.
REQ-040 alu transfer with rd=0, val=99 -> alu_ready=1, en_w stays 0; iss_rd=0 -> q_rs1_busy=0 for q_rs1=0.
REQ-041 rst asserted asynchronously between edges during a transfer cycle -> en_w=0, all busy=0 immediately; en_w=0 first cycle after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared writeback-path constants and helpers used by the regfile writer
// and its scoreboard.
package riscv_pkg;

  localparam int XLEN         = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;
  localparam int STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_MEM  = 2'd2
  } wb_src_e;

  // One-hot register select; x0 never maps to a bit so it can't become busy.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    v[0] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set on
// issue, cleared on writeback transfer, with two combinational query ports.
module wb_scoreboard (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [4:0] set_rd,
  input  logic       clr_en,
  input  logic [4:0] clr_rd,
  input  logic [4:0] q_rs1,
  input  logic [4:0] q_rs2,
  output logic       q_rs1_busy,
  output logic       q_rs2_busy
);
  import riscv_pkg::*;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  always_comb begin
    set_vec = set_en ? reg_onehot(set_rd) : '0;
    clr_vec = clr_en ? reg_onehot(clr_rd) : '0;
    // Set is applied after clear so a same-edge reissue keeps the bit.
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign q_rs1_busy = busy_q[q_rs1];
  assign q_rs2_busy = busy_q[q_rs2];

endmodule

// File: rtl/regfile_writer.sv
// Writeback arbiter: merges ALU and load results into a single registered
// regfile write port, with anti-starvation for the ALU and a busy scoreboard.
module regfile_writer #(
  parameter int XLEN         = riscv_pkg::XLEN,
  parameter int STARVE_LIMIT = riscv_pkg::STARVE_LIMIT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_val,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_val,
  output logic            mem_ready,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      q_rs1,
  input  logic [4:0]      q_rs2,
  output logic            q_rs1_busy,
  output logic            q_rs2_busy,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] val_w,
  output logic            en_w
);
  import riscv_pkg::*;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  wb_src_e         grant;
  logic            starved;
  logic            xfer;
  logic [4:0]      xfer_rd;
  logic [XLEN-1:0] xfer_val;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic [4:0]       rd_q, rd_d;
  logic [XLEN-1:0]  val_q, val_d;

  assign starved = (cnt_q == CNT_W'(STARVE_LIMIT));

  // Load results have priority unless the ALU has lost STARVE_LIMIT times in a row.
  always_comb begin
    grant = SRC_NONE;
    if (!rst) begin
      if (alu_valid && (!mem_valid || starved)) begin
        grant = SRC_ALU;
      end else if (mem_valid) begin
        grant = SRC_MEM;
      end
    end
  end

  assign alu_ready = (grant == SRC_ALU);
  assign mem_ready = (grant == SRC_MEM);

  always_comb begin
    xfer     = 1'b0;
    xfer_rd  = '0;
    xfer_val = '0;
    case (grant)
      SRC_ALU: begin
        xfer     = 1'b1;
        xfer_rd  = alu_rd;
        xfer_val = alu_val;
      end
      SRC_MEM: begin
        xfer     = 1'b1;
        xfer_rd  = mem_rd;
        xfer_val = mem_val;
      end
      default: begin
        xfer     = 1'b0;
        xfer_rd  = '0;
        xfer_val = '0;
      end
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (alu_valid && !alu_ready) begin
      cnt_d = starved ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  // x0 writes are consumed from the source but never reach the regfile.
  always_comb begin
    en_d  = xfer && (xfer_rd != 5'd0);
    rd_d  = rd_q;
    val_d = val_q;
    if (xfer) begin
      rd_d  = xfer_rd;
      val_d = xfer_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
      rd_q  <= '0;
      val_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
      rd_q  <= rd_d;
      val_q <= val_d;
    end
  end

  assign en_w  = en_q;
  assign rd    = rd_q;
  assign val_w = val_q;

  wb_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en     (iss_valid),
    .set_rd     (iss_rd),
    .clr_en     (xfer),
    .clr_rd     (xfer_rd),
    .q_rs1      (q_rs1),
    .q_rs2      (q_rs2),
    .q_rs1_busy (q_rs1_busy),
    .q_rs2_busy (q_rs2_busy)
  );

endmodule

// File: tb/tb_regfile_writer.sv
// Bench for regfile_writer: directed vector table, multi-cycle corner
// sequences, and a randomized run against a behavioural model.
module tb_regfile_writer;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, iss_valid;
  logic [4:0]  alu_rd, mem_rd, iss_rd, q_rs1, q_rs2;
  logic [31:0] alu_val, mem_val;
  logic        alu_ready, mem_ready, q_rs1_busy, q_rs2_busy, en_w;
  logic [4:0]  rd;
  logic [31:0] val_w;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_writer dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_val(alu_val), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_val(mem_val), .mem_ready(mem_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rs1_busy(q_rs1_busy), .q_rs2_busy(q_rs2_busy),
    .rd(rd), .val_w(val_w), .en_w(en_w)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_val = 0;
    mem_valid = 0; mem_rd = 0; mem_val = 0;
    iss_valid = 0; iss_rd = 0; q_rs1 = 0; q_rs2 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] aval;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mval;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  q1;
    logic        e_ar;
    logic        e_mr;
    logic        e_q1b;
    logic        e_en;
    logic [4:0]  e_rd;
    logic [31:0] e_val;
    logic        chk_d;
  } vec_t;

  vec_t tbl[9];

  // Behavioural reference state for the random phase
  bit          m_busy[32];
  int          m_starve;
  logic        m_en;
  logic [4:0]  m_rd;
  logic [31:0] m_val;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic e_ar, e_mr, a_x, m_x, a_hold, m_hold;

    // Reset state, with sources requesting so ready gating is visible
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    alu_valid = 1; mem_valid = 1; q_rs1 = 5'd5; q_rs2 = 5'd9;
    #1;
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_en_w", en_w, 0);
    chk("rst_rd", rd, 0);
    chk("rst_val_w", val_w, 0);
    chk("rst_q1_busy", q_rs1_busy, 0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_en_w", en_w, 0);
    @(negedge clk);

    // Directed vector table, applied back to back from the reset state
    tbl[0] = '{1, 5, 24,  0, 0, 0,  0, 0, 0,  1, 0, 0,  1, 5, 24,  1};
    tbl[1] = '{1, 3, 7,   1, 4, 9,  0, 0, 0,  0, 1, 0,  1, 4, 9,   1};
    tbl[2] = '{1, 3, 7,   0, 0, 0,  0, 0, 0,  1, 0, 0,  1, 3, 7,   1};
    tbl[3] = '{0, 0, 0,   0, 0, 0,  1, 7, 7,  0, 0, 0,  0, 3, 7,   1};
    tbl[4] = '{1, 7, 55,  0, 0, 0,  0, 0, 7,  1, 0, 1,  1, 7, 55,  1};
    tbl[5] = '{1, 7, 66,  0, 0, 0,  1, 7, 7,  1, 0, 0,  1, 7, 66,  1};
    tbl[6] = '{1, 0, 99,  0, 0, 0,  1, 0, 7,  1, 0, 1,  0, 0, 0,   0};
    tbl[7] = '{0, 0, 0,   0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,   0};
    tbl[8] = '{0, 0, 0,   0, 0, 0,  0, 0, 7,  0, 0, 1,  0, 0, 0,   0};
    for (int i = 0; i < 9; i++) begin
      alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_val = tbl[i].aval;
      mem_valid = tbl[i].mv; mem_rd = tbl[i].mrd; mem_val = tbl[i].mval;
      iss_valid = tbl[i].iv; iss_rd = tbl[i].ird; q_rs1 = tbl[i].q1; q_rs2 = 0;
      #1;
      chk($sformatf("v%0d_alu_ready", i), alu_ready, tbl[i].e_ar);
      chk($sformatf("v%0d_mem_ready", i), mem_ready, tbl[i].e_mr);
      chk($sformatf("v%0d_q1_busy", i), q_rs1_busy, tbl[i].e_q1b);
      chk($sformatf("v%0d_q2_busy_x0", i), q_rs2_busy, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_en_w", i), en_w, tbl[i].e_en);
      if (tbl[i].chk_d) begin
        chk($sformatf("v%0d_rd", i), rd, tbl[i].e_rd);
        chk($sformatf("v%0d_val_w", i), val_w, tbl[i].e_val);
      end
      @(negedge clk);
    end
    idle_inputs();

    // Anti-starvation: ALU loses four times, wins the fifth, then mem again
    do_reset();
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1; alu_rd = 5'd10; alu_val = 32'h100;
      mem_valid = 1; mem_rd = 5'd11; mem_val = 32'h200 + c;
      #1;
      chk($sformatf("starve%0d_alu_ready", c), alu_ready, (c == 4));
      chk($sformatf("starve%0d_mem_ready", c), mem_ready, (c != 4));
      @(posedge clk); #1;
      chk($sformatf("starve%0d_en_w", c), en_w, 1);
      chk($sformatf("starve%0d_rd", c), rd, (c == 4) ? 5'd10 : 5'd11);
      chk($sformatf("starve%0d_val_w", c), val_w, (c == 4) ? 32'h100 : 32'h200 + c);
      @(negedge clk);
    end
    idle_inputs();

    // Asynchronous reset during the cycle a write is being presented
    do_reset();
    iss_valid = 1; iss_rd = 5'd12; q_rs1 = 5'd12;
    @(negedge clk);
    iss_valid = 0; alu_valid = 1; alu_rd = 5'd9; alu_val = 32'd77;
    #1;
    chk("arst_q1_busy_pre", q_rs1_busy, 1);
    chk("arst_alu_ready_pre", alu_ready, 1);
    @(posedge clk); #2;
    chk("arst_en_w_pre", en_w, 1);
    chk("arst_rd_pre", rd, 9);
    rst = 1'b1;
    #1;
    chk("arst_en_w", en_w, 0);
    chk("arst_rd", rd, 0);
    chk("arst_val_w", val_w, 0);
    chk("arst_q1_busy", q_rs1_busy, 0);
    chk("arst_alu_ready", alu_ready, 0);
    @(negedge clk);
    alu_valid = 0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_release_en_w", en_w, 0);

    // Reset raised between edges while a handshake is pending discards it
    @(negedge clk);
    alu_valid = 1; alu_rd = 5'd14; alu_val = 32'd5;
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("arst2_en_w", en_w, 0);
    @(negedge clk);
    alu_valid = 0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst2_release_en_w", en_w, 0);
    chk("arst2_rd", rd, 0);

    // Randomized run against the behavioural model
    do_reset();
    foreach (m_busy[r]) m_busy[r] = 0;
    m_starve = 0; m_en = 0; m_rd = 0; m_val = 0;
    a_hold = 0; m_hold = 0;
    for (int n = 0; n < 600; n++) begin
      if (!a_hold) begin
        alu_valid = ($urandom_range(0, 99) < 60);
        alu_rd    = 5'($urandom_range(0, 31));
        alu_val   = $urandom;
      end
      if (!m_hold) begin
        mem_valid = ($urandom_range(0, 99) < 55);
        mem_rd    = 5'($urandom_range(0, 31));
        mem_val   = $urandom;
      end
      iss_valid = ($urandom_range(0, 99) < 40);
      iss_rd    = 5'($urandom_range(0, 31));
      q_rs1     = 5'($urandom_range(0, 31));
      q_rs2     = 5'($urandom_range(0, 31));

      e_ar = alu_valid && (!mem_valid || m_starve == STARVE_LIMIT);
      e_mr = mem_valid && !e_ar;
      #1;
      chk("rnd_alu_ready", alu_ready, e_ar);
      chk("rnd_mem_ready", mem_ready, e_mr);
      chk("rnd_q1_busy", q_rs1_busy, (q_rs1 != 0) && m_busy[q_rs1]);
      chk("rnd_q2_busy", q_rs2_busy, (q_rs2 != 0) && m_busy[q_rs2]);

      a_x = alu_valid && e_ar;
      m_x = mem_valid && e_mr;
      if (a_x) begin
        m_en = (alu_rd != 0); m_rd = alu_rd; m_val = alu_val; m_busy[alu_rd] = 0;
      end else if (m_x) begin
        m_en = (mem_rd != 0); m_rd = mem_rd; m_val = mem_val; m_busy[mem_rd] = 0;
      end else begin
        m_en = 0;
      end
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
      m_starve = (alu_valid && !e_ar) ? ((m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT) : 0;
      a_hold = alu_valid && !e_ar;
      m_hold = mem_valid && !e_mr;

      @(posedge clk); #1;
      chk("rnd_en_w", en_w, m_en);
      if (m_en) begin
        chk("rnd_rd", rd, m_rd);
        chk("rnd_val_w", val_w, m_val);
      end
      @(negedge clk);
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
